// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the imem address bus, holds the PC, and feeds decode
// through a one-entry valid/ready register. Debug reads are served while idle or halted.
module imem_fetch_ctrl #(
   parameter int                ADDR_W    = 10,
   parameter int                DATA_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic              halted,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_data
);

   // state   | meaning
   // IDLE    | after reset; memory available to debug, waits for start
   // RUN     | fetching from pc into the output register
   // HALT    | sentinel fetched; memory available to debug, waits for start
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic              load;

   assign load      = !out_valid || out_ready;
   assign imem_addr = (state != ST_RUN && dbg_req) ? dbg_addr : pc;
   assign halted    = (state == ST_HALT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         pc        <= RESET_PC;
         out_valid <= 1'b0;
         out_instr <= '0;
         out_pc    <= '0;
         dbg_ack   <= 1'b0;
         dbg_data  <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_HALT: begin
               // start takes priority; a simultaneous debug request waits a cycle
               if (start) begin
                  state   <= ST_RUN;
                  pc      <= RESET_PC;
                  dbg_ack <= 1'b0;
               end else if (dbg_req && !dbg_ack) begin
                  dbg_data <= imem_data;
                  dbg_ack  <= 1'b1;
               end else begin
                  dbg_ack <= 1'b0;
               end
            end
            ST_RUN: begin
               dbg_ack <= 1'b0;
               if (redirect_valid) begin
                  out_valid <= 1'b0;
                  pc        <= redirect_addr;
               end else if (load) begin
                  if (imem_data == HALT_WORD) begin
                     // pc stays on the sentinel; it is never handed to decode
                     out_valid <= 1'b0;
                     state     <= ST_HALT;
                  end else begin
                     out_instr <= imem_data;
                     out_pc    <= pc;
                     out_valid <= 1'b1;
                     pc        <= pc + ADDR_W'(1);
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the fetch/debug rules.
module tb_imem_fetch_ctrl;

   localparam int          NWORDS = 1024;
   localparam logic [31:0] HALTW  = 32'hFFFF_FFFF;

   logic        clk;
   logic        rst;
   logic        start;
   logic [9:0]  imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [9:0]  redirect_addr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [9:0]  out_pc;
   logic        halted;
   logic        dbg_req;
   logic [9:0]  dbg_addr;
   logic        dbg_ack;
   logic [31:0] dbg_data;

   logic [31:0] mem [0:NWORDS-1];
   assign imem_data = mem[imem_addr];

   imem_fetch_ctrl dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .halted(halted),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr),
      .dbg_ack(dbg_ack), .dbg_data(dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: running/halted flags, pc, the output slot and the debug reply.
   bit          m_run, m_halt, m_ov, m_ack;
   int          m_pc, m_opc;
   logic [31:0] m_oi, m_dd;

   function automatic int exp_addr();
      return (!m_run && dbg_req) ? int'(dbg_addr) : m_pc;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run = 0; m_halt = 0; m_ov = 0; m_ack = 0;
         m_pc = 0; m_opc = 0; m_oi = '0; m_dd = '0;
      end else begin
         automatic logic [31:0] w = mem[exp_addr()];
         if (!m_run) begin
            if (start) begin
               m_run = 1; m_halt = 0; m_pc = 0; m_ack = 0;
            end else if (dbg_req && !m_ack) begin
               m_dd = w; m_ack = 1;
            end else begin
               m_ack = 0;
            end
         end else begin
            m_ack = 0;
            if (redirect_valid) begin
               m_ov = 0; m_pc = int'(redirect_addr);
            end else if (!m_ov || out_ready) begin
               if (w == HALTW) begin
                  m_ov = 0; m_run = 0; m_halt = 1;
               end else begin
                  m_oi = w; m_opc = m_pc; m_ov = 1; m_pc = (m_pc + 1) % NWORDS;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && chk_en) begin
         check("out_valid", 32'(out_valid), 32'(m_ov));
         check("out_instr", out_instr, m_oi);
         check("out_pc",    32'(out_pc), 32'(m_opc));
         check("halted",    32'(halted), 32'(m_halt));
         check("dbg_ack",   32'(dbg_ack), 32'(m_ack));
         check("dbg_data",  dbg_data, m_dd);
         check("imem_addr", 32'(imem_addr), 32'(exp_addr()));
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic beat(input int pc, input logic [31:0] instr);
      check("beat_valid", 32'(out_valid), 32'd1);
      check("beat_pc",    32'(out_pc), 32'(pc));
      check("beat_instr", out_instr, instr);
   endtask

   initial begin
      for (int i = 0; i < NWORDS; i++) mem[i] = 32'h1000_0000 + 32'(i);
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = HALTW;
      mem[10'h210] = HALTW;
      rst = 1; start = 0; redirect_valid = 0; redirect_addr = '0;
      out_ready = 1; dbg_req = 0; dbg_addr = '0;
      repeat (2) @(negedge clk);
      #1 rst = 0; chk_en = 1;

      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_addr", 32'(imem_addr), 32'd0);
      cyc();
      check("idle_valid", 32'(out_valid), 32'd0);

      // basic stream into the sentinel
      start = 1; cyc(); start = 0;
      check("run_addr", 32'(imem_addr), 32'd0);
      check("run_valid", 32'(out_valid), 32'd0);
      cyc(); beat(0, 32'h11);
      cyc(); beat(1, 32'h22);
      cyc(); beat(2, 32'h33);
      cyc();
      check("halt_set", 32'(halted), 32'd1);
      check("halt_novalid", 32'(out_valid), 32'd0);

      // debug read while halted
      dbg_req = 1; dbg_addr = 10'd3; #1;
      check("dbg_addr_mux", 32'(imem_addr), 32'd3);
      cyc();
      check("dbg_ack", 32'(dbg_ack), 32'd1);
      check("dbg_data", dbg_data, HALTW);
      dbg_req = 0; cyc();
      check("dbg_ack_drop", 32'(dbg_ack), 32'd0);

      // restart, then redirect to 4 before anything is fetched
      start = 1; cyc(); start = 0;
      redirect_valid = 1; redirect_addr = 10'd4; cyc(); redirect_valid = 0;
      check("redir_bubble", 32'(out_valid), 32'd0);
      cyc(); beat(4, 32'h1000_0004);
      cyc(); beat(5, 32'h1000_0005);

      // redirect while holding pc 5
      redirect_valid = 1; redirect_addr = 10'h200; cyc(); redirect_valid = 0;
      check("redir200_bubble", 32'(out_valid), 32'd0);
      cyc(); beat(10'h200, 32'h1000_0200);
      cyc(); beat(10'h201, 32'h1000_0201);

      // backpressure
      out_ready = 0;
      repeat (3) begin
         cyc(); beat(10'h201, 32'h1000_0201);
         check("stall_pc", 32'(imem_addr), 32'h202);
      end
      check("model_pc_pin", 32'(m_pc), 32'h202);
      out_ready = 1;
      cyc(); beat(10'h202, 32'h1000_0202);
      cyc(); beat(10'h203, 32'h1000_0203);

      // redirect coinciding with a sentinel fetch, then wrap-around
      redirect_valid = 1; redirect_addr = 10'h210; cyc();
      check("at_sentinel", 32'(imem_data), HALTW);
      redirect_addr = 10'd1022; cyc(); redirect_valid = 0;
      check("no_halt", 32'(halted), 32'd0);
      check("wrap_bubble", 32'(out_valid), 32'd0);
      cyc(); beat(1022, 32'h1000_03FE);
      cyc(); beat(1023, 32'h1000_03FF);
      cyc(); beat(0, 32'h11);

      // debug request raised during RUN stalls until halt
      dbg_req = 1; dbg_addr = 10'd1;
      cyc(); beat(1, 32'h22);
      check("dbg_stall1", 32'(dbg_ack), 32'd0);
      cyc(); beat(2, 32'h33);
      check("dbg_stall2", 32'(dbg_ack), 32'd0);
      cyc();
      check("halt2", 32'(halted), 32'd1);
      check("dbg_stall3", 32'(dbg_ack), 32'd0);
      cyc();
      check("dbg_ack2", 32'(dbg_ack), 32'd1);
      check("dbg_data2", dbg_data, 32'h22);
      cyc();
      check("dbg_gap", 32'(dbg_ack), 32'd0);
      cyc();
      check("dbg_reack", 32'(dbg_ack), 32'd1);
      dbg_req = 0; cyc();

      // asynchronous reset mid-stream
      start = 1; cyc(); start = 0;
      cyc(); beat(0, 32'h11);
      #2 rst = 1; #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_halted", 32'(halted), 32'd0);
      check("arst_ack", 32'(dbg_ack), 32'd0);
      cyc(); rst = 0;
      repeat (3) begin
         cyc();
         check("post_rst_idle", 32'(out_valid), 32'd0);
         check("post_rst_addr", 32'(imem_addr), 32'd0);
      end
      start = 1; cyc(); start = 0;
      cyc(); beat(0, 32'h11);

      // random traffic
      for (int i = 0; i < NWORDS; i++)
         mem[i] = ($urandom_range(0, 15) == 0) ? HALTW : $urandom;
      for (int n = 0; n < 4000; n++) begin
         start          = ($urandom_range(0, 19) == 0);
         redirect_valid = ($urandom_range(0, 7) == 0);
         redirect_addr  = 10'($urandom_range(0, 1023));
         out_ready      = ($urandom_range(0, 9) < 7);
         if (dbg_req && dbg_ack) begin
            dbg_req = 0;
         end else if (!dbg_req && $urandom_range(0, 5) == 0) begin
            dbg_req  = 1;
            dbg_addr = 10'($urandom_range(0, 1023));
         end
         if ($urandom_range(0, 499) == 0) begin
            rst = 1; cyc(); rst = 0;
         end
         cyc();
      end

      cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch sequencer for the 1024 x 32 instruction memory, which has a combinational read (address in, word out in the same cycle). It owns the memory address bus and holds the program counter. It delivers fetched words to decode through a one-entry valid/ready output register, and handles branch redirects and a halt sentinel. While the core is idle or halted, it also grants the memory to a debug read port.

## Interface
- ADDR_W, 10, instruction memory address width (word address)
- DATA_W, 32, instruction width
- RESET_PC, 0, PC value after reset and on every start
- HALT_WORD, 32'hFFFF_FFFF, sentinel instruction that stops fetch

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins fetch from RESET_PC (honoured in IDLE or HALT only)
- imem_addr  out  ADDR_W  address to instruction memory
- imem_data  in  DATA_W  word returned combinationally for imem_addr
- redirect_valid  in  1  branch/jump taken
- redirect_addr  in  ADDR_W  redirect target
- out_valid  out  1  out_instr/out_pc hold a fetched instruction
- out_ready  in  1  decode accepts this cycle
- out_instr  out  DATA_W  fetched instruction
- out_pc  out  ADDR_W  address of out_instr
- halted  out  1  high while in HALT
- dbg_req  in  1  debug read request, held until dbg_ack
- dbg_addr  in  ADDR_W  debug read address
- dbg_ack  out  1  one-cycle pulse; dbg_data valid
- dbg_data  out  DATA_W  debug read result

## Operation

States:
- IDLE: entered at reset. start → RUN, pc ← RESET_PC.
- RUN: normal fetch. Fetching HALT_WORD → HALT.
- HALT: start → RUN, pc ← RESET_PC.

Address mux:
- imem_addr = pc in RUN.
- In IDLE/HALT, imem_addr = dbg_addr while dbg_req=1, otherwise pc.

Fetch rules in RUN, evaluated in priority order each cycle:
- redirect_valid=1: out_valid ← 0; pc ← redirect_addr; no fetch this cycle.
- Fetch condition: load = !out_valid || out_ready.
- load with imem_data ≠ HALT_WORD: out_instr ← imem_data; out_pc ← pc; out_valid ← 1; pc ← pc+1.
- load with imem_data = HALT_WORD: out_valid ← 0; pc unchanged (points at the sentinel); state ← HALT. The sentinel is never presented to decode.
- No load: out_valid, out_instr and out_pc hold stable; pc holds.

Arithmetic and boundaries:
- PC increment is modulo 2^ADDR_W: 1023+1 → 0. No error is raised.
- A redirect in the same cycle as a HALT_WORD fetch: the redirect wins and the state stays RUN.
- out_ready is ignored while out_valid=0.

Debug port:
- In IDLE/HALT with dbg_req=1 and dbg_ack=0: dbg_data ← imem_data; dbg_ack ← 1 for exactly one cycle.
- A request still held the following cycle is served again one cycle later, so a held request acks every second cycle.
- In RUN, dbg_req is stalled with no ack until the block reaches IDLE or HALT.
- start and dbg_req in the same cycle: start wins; the request is deferred.

Reset (asynchronous, any state):
- state ← IDLE; pc ← RESET_PC; out_valid, out_instr, out_pc ← 0; halted, dbg_ack, dbg_data ← 0.
- An in-flight fetch or debug read is discarded.

## Timing
- All outputs are registered except imem_addr, which is combinational from state, pc and the debug inputs.
- halted = (state == HALT), decoded from the registered state.
- start sampled at edge t: state=RUN and imem_addr=RESET_PC after t; out_valid=1 with mem[RESET_PC] after t+1.
- Throughput with out_ready held high: one instruction per cycle.
- Redirect sampled at edge t: a one-cycle bubble; the target instruction appears after t+1.
- Debug latency: dbg_ack one cycle after dbg_req is first sampled in IDLE/HALT.
- HALT_WORD fetched at edge t: halted=1 after t.

## Test plan
- Memory mem[0..3] = 11,22,33,FFFFFFFF, pulse start, out_ready=1 → out_instr 11,22,33 on consecutive cycles with out_pc 0,1,2; halted=1 one cycle after the 33 beat; the sentinel is never valid.
- Backpressure: out_ready=0 for 3 cycles mid-stream → out_instr/out_pc stay stable and pc does not advance; release → the stream resumes with no loss or duplication.
- Redirect to 0x200 while out_valid=1 holding pc 5 → out_valid drops for one cycle, then out_pc=0x200 followed by 0x201; a redirect coinciding with a HALT_WORD fetch → no halt.
- Wrap-around: redirect to 1022 with no sentinel in the path → out_pc sequence 1022, 1023, 0, 1.
- Debug: in HALT, dbg_req with dbg_addr=3 → dbg_ack one cycle later with dbg_data=mem[3]; dbg_req raised during RUN → no ack until halted, then ack.
- Assert rst mid-stream with out_valid=1 → out_valid, halted and dbg_ack go low immediately (asynchronously); after rst is released, the block stays IDLE until start and restarts fetch at RESET_PC.
